// File: rtl/apple_1_pia.sv
// Apple-I keyboard/display PIA (6821 subset) bus responder.
// Registered read data and hit flag, one cycle after the address.
module apple_1_pia #(
  parameter logic [15:0] BASE = 16'hD010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DI,
  input  logic        WE,
  output logic [7:0]  DO,
  output logic        sel,
  input  logic [6:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready
);

  logic [1:0] rst_pipe;
  logic       rst_n;

  logic [6:0] kbd_char;
  logic       key_avail;
  logic [6:0] kbdcr;
  logic [6:0] dspcr;
  logic [6:0] ddr;
  logic [6:0] dsp_char;
  logic       busy;

  logic       hit;
  logic [1:0] offset;
  logic       kbd_accept;
  logic       kbd_read;
  logic       dsp_handshake;
  logic       dsp_write;
  logic       dsp_load;
  logic [7:0] read_mux;
  logic       unused_bits;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign hit           = (AB[15:2] == BASE[15:2]);
  assign offset        = AB[1:0];
  assign kbd_accept    = kbd_valid && !key_avail;
  assign kbd_read      = hit && !WE && (offset == 2'd0);
  assign dsp_handshake = busy && dsp_ready;
  assign dsp_write     = hit && WE && (offset == 2'd2) && dspcr[2];
  assign dsp_load      = dsp_write && (!busy || dsp_handshake);

  // DDR is write-only on this bus and DI[7] is never stored.
  assign unused_bits = ^{DI[7], ddr};

  always_comb begin
    read_mux = 8'h00;
    case (offset)
      2'd0: read_mux = {1'b1, kbd_char};
      2'd1: read_mux = {key_avail, kbdcr};
      2'd2: read_mux = {busy, dsp_char};
      2'd3: read_mux = {1'b0, dspcr};
      default: read_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DO  <= 8'h00;
      sel <= 1'b0;
    end else begin
      DO  <= hit ? read_mux : 8'h00;
      sel <= hit;
    end
  end

  // Acceptance needs key_avail low, so it never collides with a KBD read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_char  <= 7'h00;
      key_avail <= 1'b0;
    end else if (kbd_accept) begin
      kbd_char  <= kbd_data;
      key_avail <= 1'b1;
    end else if (kbd_read) begin
      key_avail <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbdcr <= 7'h00;
      dspcr <= 7'h00;
      ddr   <= 7'h00;
    end else if (hit && WE) begin
      case (offset)
        2'd1: kbdcr <= DI[6:0];
        2'd2: if (!dspcr[2]) ddr <= DI[6:0];
        2'd3: dspcr <= DI[6:0];
        default: ;
      endcase
    end
  end

  // A load on the handshake edge retires the old character and keeps busy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_char <= 7'h00;
      busy     <= 1'b0;
    end else if (dsp_load) begin
      dsp_char <= DI[6:0];
      busy     <= 1'b1;
    end else if (dsp_handshake) begin
      busy <= 1'b0;
    end
  end

  assign kbd_ready = !key_avail;
  assign dsp_data  = dsp_char;
  assign dsp_valid = busy;

endmodule

// File: tb/tb_apple_1_pia.sv
// Directed self-checking bench for apple_1_pia.
module tb_apple_1_pia;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DI;
  logic        WE;
  logic [7:0]  DO;
  logic        sel;
  logic [6:0]  kbd_data;
  logic        kbd_valid;
  logic        kbd_ready;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] IDLE_ADDR = 16'hFF00;

  apple_1_pia #(.BASE(16'hD010)) dut (
    .clk(clk), .reset(reset), .AB(AB), .DI(DI), .WE(WE), .DO(DO), .sel(sel),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] addr);
    AB = addr; WE = 1'b0;
    tick();
    AB = IDLE_ADDR;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    AB = addr; DI = data; WE = 1'b1;
    tick();
    WE = 1'b0; AB = IDLE_ADDR;
  endtask

  task automatic test_reset();
    logic [7:0] exp_do [4];
    exp_do[0] = 8'h80; exp_do[1] = 8'h00; exp_do[2] = 8'h00; exp_do[3] = 8'h00;
    n_checks++;
    if (DO !== 8'h00 || sel !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_do_sel: DO=%h sel=%b, want 00/0", DO, sel);
    end
    n_checks++;
    if (kbd_ready !== 1'b1 || dsp_valid !== 1'b0 || dsp_data !== 7'h00) begin
      n_fail++; $display("[TB] FAIL reset_handshake: kbd_ready=%b dsp_valid=%b dsp_data=%h, want 1/0/00", kbd_ready, dsp_valid, dsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(16'hD010 + 16'(i));
      n_checks++;
      if (DO !== exp_do[i] || sel !== 1'b1) begin
        n_fail++; $display("[TB] FAIL reset_read%0d: DO=%h sel=%b, want %h/1", i, DO, sel, exp_do[i]);
      end
    end
    tick();
    n_checks++;
    if (sel !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sel_drop: sel=%b, want 0", sel);
    end
  endtask

  task automatic test_monitor_init();
    do_write(16'hD012, 8'h7F);
    n_checks++;
    if (dsp_valid !== 1'b0 || dsp_data !== 7'h00) begin
      n_fail++; $display("[TB] FAIL ddr_write: dsp_valid=%b dsp_data=%h, want 0/00", dsp_valid, dsp_data);
    end
    do_write(16'hD011, 8'hA7);
    do_write(16'hD013, 8'hA7);
    do_read(16'hD011);
    n_checks++;
    if (DO !== 8'h27) begin
      n_fail++; $display("[TB] FAIL kbdcr_read: DO=%h, want 27", DO);
    end
    do_read(16'hD013);
    n_checks++;
    if (DO !== 8'h27) begin
      n_fail++; $display("[TB] FAIL dspcr_read: DO=%h, want 27", DO);
    end
  endtask

  task automatic test_key_path();
    kbd_data = 7'h41; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    n_checks++;
    if (kbd_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL kbd_ready_fall: kbd_ready=%b, want 0", kbd_ready);
    end
    kbd_data = 7'h55; kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    do_read(16'hD011);
    n_checks++;
    if (DO !== 8'hA7) begin
      n_fail++; $display("[TB] FAIL kbdcr_avail: DO=%h, want A7", DO);
    end
    do_read(16'hD010);
    n_checks++;
    if (DO !== 8'hC1 || kbd_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL kbd_read: DO=%h kbd_ready=%b, want C1/1", DO, kbd_ready);
    end
    do_read(16'hD011);
    n_checks++;
    if (DO !== 8'h27) begin
      n_fail++; $display("[TB] FAIL kbdcr_cleared: DO=%h, want 27", DO);
    end
  endtask

  task automatic test_echo();
    dsp_ready = 1'b0;
    do_write(16'hD012, 8'hCD);
    n_checks++;
    if (dsp_data !== 7'h4D || dsp_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL echo_load: dsp_data=%h dsp_valid=%b, want 4D/1", dsp_data, dsp_valid);
    end
    do_read(16'hD012);
    n_checks++;
    if (DO !== 8'hCD) begin
      n_fail++; $display("[TB] FAIL dsp_read: DO=%h, want CD", DO);
    end
    do_write(16'hD012, 8'hC1);
    n_checks++;
    if (dsp_data !== 7'h4D || dsp_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL busy_drop: dsp_data=%h dsp_valid=%b, want 4D/1", dsp_data, dsp_valid);
    end
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    n_checks++;
    if (dsp_valid !== 1'b0 || dsp_data !== 7'h4D) begin
      n_fail++; $display("[TB] FAIL echo_done: dsp_valid=%b dsp_data=%h, want 0/4D", dsp_valid, dsp_data);
    end
  endtask

  task automatic test_simultaneous();
    do_write(16'hD012, 8'hC5);
    dsp_ready = 1'b1;
    do_write(16'hD012, 8'hC2);
    n_checks++;
    if (dsp_data !== 7'h42 || dsp_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hs_reload: dsp_data=%h dsp_valid=%b, want 42/1", dsp_data, dsp_valid);
    end
    tick();
    dsp_ready = 1'b0;
    n_checks++;
    if (dsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hs_retire: dsp_valid=%b, want 0", dsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] chars [3];
    chars[0] = 8'hC8; chars[1] = 8'hC9; chars[2] = 8'hA1;
    dsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_write(16'hD012, chars[i]);
      n_checks++;
      if (dsp_valid !== 1'b1 || dsp_data !== chars[i][6:0]) begin
        n_fail++; $display("[TB] FAIL b2b_%0d: dsp_valid=%b dsp_data=%h, want 1/%h", i, dsp_valid, dsp_data, chars[i][6:0]);
      end
    end
    tick();
    n_checks++;
    if (dsp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_end: dsp_valid=%b, want 0", dsp_valid);
    end
    dsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_write(16'hD012, 8'hD8);
    kbd_data = 7'h33; kbd_valid = 1'b1;
    AB = 16'hD011;
    tick();
    kbd_valid = 1'b0;
    n_checks++;
    if (dsp_valid !== 1'b1 || kbd_ready !== 1'b0 || sel !== 1'b1) begin
      n_fail++; $display("[TB] FAIL pre_reset: dsp_valid=%b kbd_ready=%b sel=%b, want 1/0/1", dsp_valid, kbd_ready, sel);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (DO !== 8'h00 || sel !== 1'b0 || kbd_ready !== 1'b1 || dsp_valid !== 1'b0 || dsp_data !== 7'h00) begin
      n_fail++; $display("[TB] FAIL mid_reset: DO=%h sel=%b kbd_ready=%b dsp_valid=%b dsp_data=%h, want 00/0/1/0/00", DO, sel, kbd_ready, dsp_valid, dsp_data);
    end
    AB = IDLE_ADDR;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    do_read(16'hD013);
    n_checks++;
    if (DO !== 8'h00 || sel !== 1'b1) begin
      n_fail++; $display("[TB] FAIL post_reset_dspcr: DO=%h sel=%b, want 00/1", DO, sel);
    end
  endtask

  initial begin
    reset = 1'b0; AB = IDLE_ADDR; DI = 8'h00; WE = 1'b0;
    kbd_data = 7'h00; kbd_valid = 1'b0; dsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    test_reset();
    test_monitor_init();
    test_key_path();
    test_echo();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
